// File: rtl/axi_mst_rd_pkg.sv
// Shared AXI widths, encodings and FSM states for the AXI read initiator.
`ifndef AXI_DEFINES_SVH
`define AXI_DEFINES_SVH
`define AXI_ID_WIDTH     4
`define AXI_ADDR_WIDTH   32
`define AXI_LEN_WIDTH    8
`define AXI_SIZE_WIDTH   3
`define AXI_BURST_WIDTH  2
`define AXI_DATA_WIDTH   64
`define AXI_RESP_WIDTH   2
`define AXI_BURST_FIXED  2'd0
`define AXI_BURST_INCR   2'd1
`define AXI_BURST_WRAP   2'd2
`define AXI_RESP_OKAY    2'd0
`define AXI_RESP_EXOKAY  2'd1
`define AXI_RESP_SLVERR  2'd2
`define AXI_RESP_DECERR  2'd3
`endif

package axi_mst_rd_pkg;
  localparam int AXI_ID_W    = `AXI_ID_WIDTH;
  localparam int AXI_ADDR_W  = `AXI_ADDR_WIDTH;
  localparam int AXI_LEN_W   = `AXI_LEN_WIDTH;
  localparam int AXI_SIZE_W  = `AXI_SIZE_WIDTH;
  localparam int AXI_BURST_W = `AXI_BURST_WIDTH;
  localparam int AXI_DATA_W  = `AXI_DATA_WIDTH;
  localparam int AXI_RESP_W  = `AXI_RESP_WIDTH;

  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = `AXI_BURST_INCR;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = `AXI_BURST_WRAP;
  localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = `AXI_RESP_OKAY;
  localparam logic [AXI_RESP_W-1:0]  RESP_SLVERR = `AXI_RESP_SLVERR;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Worst response is the numerically largest code.
  function automatic logic [AXI_RESP_W-1:0] resp_max(input logic [AXI_RESP_W-1:0] a,
                                                     input logic [AXI_RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/axi_mst_rd_addr_gen.sv
// Burst address sequencer: tracks the address of the current beat of a
// FIXED/INCR/WRAP burst. Shared with the write-side blocks.
module axi_burst_addr_gen
  import axi_mst_rd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  input  logic [AXI_ADDR_W-1:0]  addr,
  input  logic [AXI_LEN_W-1:0]   len,
  input  logic [AXI_SIZE_W-1:0]  size,
  input  logic [AXI_BURST_W-1:0] burst,
  output logic [AXI_ADDR_W-1:0]  cur
);
  logic [AXI_ADDR_W-1:0]  total_c, lo_c;
  logic [AXI_ADDR_W-1:0]  lo_q, hi_q;
  logic [AXI_SIZE_W-1:0]  size_q;
  logic [AXI_BURST_W-1:0] burst_q;
  logic [AXI_ADDR_W-1:0]  nbytes, incr, nxt;

  // Wrap window is only meaningful for power-of-two totals; other lengths
  // are excluded from checking by the user of this block.
  assign total_c = (AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size;
  assign lo_c    = addr & ~(total_c - AXI_ADDR_W'(1));
  assign nbytes  = AXI_ADDR_W'(1) << size_q;
  assign incr    = cur + nbytes;

  // Next-beat address for the latched burst type.
  always_comb begin
    nxt = cur;
    case (burst_q)
      BURST_INCR: nxt = incr;
      BURST_WRAP: nxt = (incr == hi_q) ? lo_q : incr;
      default:    nxt = cur;
    endcase
  end

  // Latch burst geometry on load, advance on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (load) begin
      cur     <= addr;
      lo_q    <= lo_c;
      hi_q    <= lo_c + total_c;
      size_q  <= size;
      burst_q <= burst;
    end else if (step) begin
      cur     <= nxt;
    end
  end
endmodule

// File: rtl/axi_mst_rd.sv
// AXI read initiator: one command at a time, issues AR, collects R beats,
// forwards them to a local consumer and checks framing, response and data.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once raised valid and its
// payload stay stable until the transfer. Exception: on R, rready follows
// usr_rready combinationally while in S_RD.
module axi_mst_rd
  import axi_mst_rd_pkg::*;
#(
  parameter int CHK_EN         = 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_CNT_WIDTH   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [AXI_ID_W-1:0]    cmd_id,
  input  logic [AXI_ADDR_W-1:0]  cmd_addr,
  input  logic [AXI_LEN_W-1:0]   cmd_len,
  input  logic [AXI_SIZE_W-1:0]  cmd_size,
  input  logic [AXI_BURST_W-1:0] cmd_burst,
  output logic [AXI_ID_W-1:0]    axi_mst_arid,
  output logic [AXI_ADDR_W-1:0]  axi_mst_araddr,
  output logic [AXI_LEN_W-1:0]   axi_mst_arlen,
  output logic [AXI_SIZE_W-1:0]  axi_mst_arsize,
  output logic [AXI_BURST_W-1:0] axi_mst_arburst,
  output logic                   axi_mst_arvalid,
  input  logic                   axi_mst_arready,
  input  logic [AXI_DATA_W-1:0]  axi_mst_rdata,
  input  logic [AXI_RESP_W-1:0]  axi_mst_rresp,
  input  logic                   axi_mst_rlast,
  input  logic                   axi_mst_rvalid,
  output logic                   axi_mst_rready,
  output logic [AXI_DATA_W-1:0]  usr_rdata,
  output logic                   usr_rvalid,
  input  logic                   usr_rready,
  output logic                   done_pulse,
  output logic [AXI_RESP_W-1:0]  done_resp,
  output logic                   err_last,
  output logic                   err_data,
  output logic                   err_timeout,
  output state_t                 dbg_state
);
  state_t                    state;
  logic [AXI_LEN_W-1:0]      beat_cnt;
  logic [TO_CNT_WIDTH-1:0]   to_cnt;
  logic                      chk_ok;
  logic [AXI_ADDR_W-1:0]     exp_addr;
  logic                      cmd_fire, beat_acc, exp_last, data_bad, timeout_hit, in_rd;

  assign in_rd          = (state == S_RD);
  assign cmd_fire       = cmd_valid & cmd_ready;
  assign axi_mst_rready = in_rd & usr_rready;
  assign usr_rvalid     = in_rd & axi_mst_rvalid;
  assign usr_rdata      = in_rd ? axi_mst_rdata : '0;
  assign beat_acc       = axi_mst_rvalid & axi_mst_rready;
  assign exp_last       = (beat_cnt == axi_mst_arlen);
  assign dbg_state      = state;

  // Error-class beats carry no meaningful payload, so they skip the pattern check.
  assign data_bad = (CHK_EN != 0) && chk_ok && (axi_mst_rresp < RESP_SLVERR) &&
                    ((axi_mst_rdata[AXI_ADDR_W-1:0] != exp_addr) ||
                     (axi_mst_rdata[AXI_ADDR_W +: AXI_ID_W] != axi_mst_arid));

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !beat_acc &&
                       (to_cnt == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  axi_burst_addr_gen u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (cmd_fire),
    .step  (beat_acc),
    .addr  (cmd_addr),
    .len   (cmd_len),
    .size  (cmd_size),
    .burst (cmd_burst),
    .cur   (exp_addr)
  );

  // Transaction FSM with registered handshake, status and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cmd_ready       <= 1'b1;
      axi_mst_arvalid <= 1'b0;
      axi_mst_arid    <= '0;
      axi_mst_araddr  <= '0;
      axi_mst_arlen   <= '0;
      axi_mst_arsize  <= '0;
      axi_mst_arburst <= '0;
      done_pulse      <= 1'b0;
      done_resp       <= RESP_OKAY;
      err_last        <= 1'b0;
      err_data        <= 1'b0;
      err_timeout     <= 1'b0;
      beat_cnt        <= '0;
      to_cnt          <= '0;
      chk_ok          <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            axi_mst_arid    <= cmd_id;
            axi_mst_araddr  <= cmd_addr;
            axi_mst_arlen   <= cmd_len;
            axi_mst_arsize  <= cmd_size;
            axi_mst_arburst <= cmd_burst;
            // Non power-of-two WRAP has no well-defined window to check against.
            chk_ok          <= (cmd_burst != BURST_WRAP) ||
                               (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                               (cmd_len == 8'd7) || (cmd_len == 8'd15);
            beat_cnt        <= '0;
            to_cnt          <= '0;
            done_resp       <= RESP_OKAY;
            err_last        <= 1'b0;
            err_data        <= 1'b0;
            err_timeout     <= 1'b0;
            cmd_ready       <= 1'b0;
            axi_mst_arvalid <= 1'b1;
            state           <= S_AR;
          end
        end
        S_AR: begin
          if (axi_mst_arready) begin
            axi_mst_arvalid <= 1'b0;
            state           <= S_RD;
          end
        end
        S_RD: begin
          if (beat_acc) begin
            beat_cnt  <= beat_cnt + AXI_LEN_W'(1);
            to_cnt    <= '0;
            done_resp <= resp_max(done_resp, axi_mst_rresp);
            if (axi_mst_rlast != exp_last) err_last <= 1'b1;
            if (data_bad) err_data <= 1'b1;
            if (axi_mst_rlast || exp_last) begin
              done_pulse <= 1'b1;
              state      <= S_DONE;
            end
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            done_resp   <= RESP_SLVERR;
            done_pulse  <= 1'b1;
            state       <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TO_CNT_WIDTH'(1);
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mst_rd.sv
// Bench for axi_mst_rd: drives commands, plays an AXI read slave returning
// the {ID, address} pattern, and scoreboards the forwarded beats.
module tb_axi_mst_rd;
  import axi_mst_rd_pkg::*;

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;
  localparam logic [1:0] R_OKAY  = 2'd0;
  localparam logic [1:0] R_SLV   = 2'd2;
  localparam logic [1:0] R_DEC   = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   cmd_valid, cmd_ready;
  logic [AXI_ID_W-1:0]    cmd_id;
  logic [AXI_ADDR_W-1:0]  cmd_addr;
  logic [AXI_LEN_W-1:0]   cmd_len;
  logic [AXI_SIZE_W-1:0]  cmd_size;
  logic [AXI_BURST_W-1:0] cmd_burst;
  logic [AXI_ID_W-1:0]    arid;
  logic [AXI_ADDR_W-1:0]  araddr;
  logic [AXI_LEN_W-1:0]   arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic                   arvalid, arready;
  logic [AXI_DATA_W-1:0]  rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast, rvalid, rready;
  logic [AXI_DATA_W-1:0]  usr_rdata;
  logic                   usr_rvalid, usr_rready;
  logic                   done_pulse;
  logic [AXI_RESP_W-1:0]  done_resp;
  logic                   err_last, err_data, err_timeout;
  state_t                 dbg_state;

  axi_mst_rd #(.CHK_EN(1), .TIMEOUT_CYCLES(16), .TO_CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .axi_mst_arid(arid), .axi_mst_araddr(araddr), .axi_mst_arlen(arlen),
    .axi_mst_arsize(arsize), .axi_mst_arburst(arburst), .axi_mst_arvalid(arvalid),
    .axi_mst_arready(arready), .axi_mst_rdata(rdata), .axi_mst_rresp(rresp),
    .axi_mst_rlast(rlast), .axi_mst_rvalid(rvalid), .axi_mst_rready(rready),
    .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
    .done_pulse(done_pulse), .done_resp(done_resp), .err_last(err_last),
    .err_data(err_data), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_usr    = 0;
  logic [AXI_DATA_W-1:0] exp_q[$];
  logic [1:0]            resp_tab[16];
  logic [3:0]            bp_pat = 4'b1001;  // usr_rready sequence 1,0,0,1

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AXI_DATA_W-1:0] mk_data(input logic [3:0] id, input logic [31:0] a);
    logic [AXI_DATA_W-1:0] d;
    d = '0;
    d[AXI_ADDR_W-1:0] = a;
    d[AXI_ADDR_W +: AXI_ID_W] = id;
    return d;
  endfunction

  // Reference beat address: step i times from the start address.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input int len, input int size,
                                             input logic [1:0] burst, input int i);
    logic [31:0] nb, tot, lo, x;
    nb  = 32'd1 << size;
    tot = nb * 32'(len + 1);
    lo  = (a / tot) * tot;
    x   = a;
    for (int k = 0; k < i; k++) begin
      if (burst == B_INCR) x = x + nb;
      else if (burst == B_WRAP) begin
        x = x + nb;
        if (x == lo + tot) x = lo;
      end
    end
    return x;
  endfunction

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic send_cmd(input logic [3:0] id, input logic [31:0] a, input int len,
                          input int size, input logic [1:0] burst);
    int guard;
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = a;
    cmd_len = AXI_LEN_W'(len); cmd_size = AXI_SIZE_W'(size); cmd_burst = burst;
    guard = 0;
    while (!cmd_ready && guard < 32) begin @(negedge clk); guard++; end
    check("cmd_ready_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("arvalid_rise", arvalid, 1);
    check("arid", arid, id);
    check("araddr", araddr, a);
    check("arlen", arlen, len);
    check("arsize", arsize, size);
    check("arburst", arburst, burst);
  endtask

  task automatic accept_ar();
    int d;
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk);
      check("ar_hold", arvalid, 1);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("ar_drop", arvalid, 0);
  endtask

  // Forward path monitor: compare a beat the consumer is taking this cycle.
  task automatic sb_take();
    if (exp_q.size() == 0) check("sb_underflow", 1, 0);
    else check("usr_rdata", usr_rdata, exp_q.pop_front());
    n_usr++;
  endtask

  task automatic run_txn(input logic [3:0] id, input logic [31:0] a, input int len, input int size,
                         input logic [1:0] burst, input int nb, input int last_at,
                         input int corrupt_at, input bit bp, input logic [1:0] exp_resp,
                         input bit exp_el, input bit exp_ed, input bit exp_to);
    int cyc, budget, cnt;
    bit acc;
    logic [AXI_DATA_W-1:0] d;
    n_usr = 0;
    cyc = 0;
    send_cmd(id, a, len, size, burst);
    accept_ar();
    for (int i = 0; i < nb; i++) begin
      d = mk_data(id, (i == corrupt_at) ? 32'h40 : model_addr(a, len, size, burst, i));
      rvalid = 1'b1; rdata = d; rresp = resp_tab[i]; rlast = (i == last_at);
      exp_q.push_back(d);
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 20) begin
        usr_rready = bp ? bp_pat[cyc % 4] : 1'b1;
        cyc++;
        #1;
        if (bp) begin
          check("rready_mirror", rready, usr_rready);
          check("usr_rvalid", usr_rvalid, 1);
        end
        if (usr_rvalid && usr_rready) begin
          sb_take();
          acc = 1'b1;
        end
        @(negedge clk);
        budget++;
      end
      if (!acc) check("beat_accept_timeout", 0, 1);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = R_OKAY; usr_rready = 1'b1;
    if (nb == 0) begin
      cnt = 0;
      budget = 0;
      while (!done_pulse && budget < 64) begin
        if (rready) cnt++;
        @(negedge clk);
        budget++;
      end
      check("timeout_cycles", cnt, 16);
    end
    check("done_pulse", done_pulse, 1);
    check("done_resp", done_resp, exp_resp);
    check("err_last", err_last, exp_el);
    check("err_data", err_data, exp_ed);
    check("err_timeout", err_timeout, exp_to);
    check("usr_beats", n_usr, nb);
    @(negedge clk);
    check("done_once", done_pulse, 0);
    check("cmd_ready_back", cmd_ready, 1);
    check("err_last_hold", err_last, exp_el);
    check("done_resp_hold", done_resp, exp_resp);
    if (nb == 0) begin
      rvalid = 1'b1;
      #1;
      check("late_rready", rready, 0);
      rvalid = 1'b0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  rid;
    logic [31:0] ra;
    logic [1:0]  rb;
    int          rl, rs;
    logic [AXI_DATA_W-1:0] d0;

    cmd_valid = 0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    arready = 0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0; usr_rready = 1'b1;
    for (int i = 0; i < 16; i++) resp_tab[i] = R_OKAY;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_usr_rvalid", usr_rvalid, 0);
    check("rst_done", done_pulse, 0);
    check("rst_done_resp", done_resp, 0);
    check("rst_errs", {err_last, err_data, err_timeout}, 0);
    check("rst_state", dbg_state, S_IDLE);
    @(negedge clk);

    // INCR, clean
    run_txn(4'd3, 32'h100, 3, 2, B_INCR, 4, 3, -1, 0, R_OKAY, 0, 0, 0);
    // WRAP clean: 0x38, 0x3C, 0x30, 0x34
    run_txn(4'd5, 32'h38, 3, 2, B_WRAP, 4, 3, -1, 0, R_OKAY, 0, 0, 0);
    // WRAP with beat 3 corrupted to 0x40
    run_txn(4'd5, 32'h38, 3, 2, B_WRAP, 4, 3, 2, 0, R_OKAY, 0, 1, 0);
    // early RLAST on beat 2 of 4
    run_txn(4'd1, 32'h200, 3, 2, B_INCR, 2, 1, -1, 0, R_OKAY, 1, 0, 0);
    // missing RLAST, len=1
    run_txn(4'd2, 32'h300, 1, 2, B_INCR, 2, -1, -1, 0, R_OKAY, 1, 0, 0);
    // consumer backpressure 1,0,0,1
    run_txn(4'd6, 32'h400, 3, 3, B_INCR, 4, 3, -1, 1, R_OKAY, 0, 0, 0);
    // SLVERR then DECERR -> worst is DECERR
    resp_tab[1] = R_SLV;
    resp_tab[2] = R_DEC;
    run_txn(4'd7, 32'h500, 3, 2, B_INCR, 4, 3, -1, 0, R_DEC, 0, 0, 0);
    resp_tab[1] = R_OKAY;
    resp_tab[2] = R_OKAY;
    // no R beats at all -> timeout
    run_txn(4'd9, 32'h600, 3, 2, B_INCR, 0, -1, -1, 0, R_SLV, 0, 0, 1);

    // randomized clean bursts
    for (int t = 0; t < 6; t++) begin
      rid = 4'($urandom_range(0, 15));
      rs  = $urandom_range(0, 3);
      rb  = 2'($urandom_range(0, 2));
      ra  = $urandom;
      if (rb == B_WRAP) begin
        rl = (1 << $urandom_range(1, 3)) - 1;
        ra = ra & ~((32'd1 << rs) - 32'd1);
      end else begin
        rl = $urandom_range(0, 7);
      end
      run_txn(rid, ra, rl, rs, rb, rl + 1, rl, -1, $urandom_range(0, 1) == 1, R_OKAY, 0, 0, 0);
    end

    // reset in the middle of a read, after one beat
    send_cmd(4'd4, 32'h700, 3, 2, B_INCR);
    accept_ar();
    d0 = mk_data(4'd4, 32'h700);
    rvalid = 1'b1; rdata = d0; rresp = R_OKAY; rlast = 1'b0; usr_rready = 1'b1;
    exp_q.push_back(d0);
    n_usr = 0;
    #1;
    if (usr_rvalid) sb_take();
    check("rst_mid_beat", n_usr, 1);
    @(negedge clk);
    rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_arvalid", arvalid, 0);
    check("rst_mid_rready", rready, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_usr_rvalid", usr_rvalid, 0);
    rst = 1'b0;
    @(negedge clk);
    run_txn(4'd3, 32'h100, 3, 2, B_INCR, 4, 3, -1, 0, R_OKAY, 0, 0, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
